seg7_result_display: RTL and testbench

- Output-side companion to the slow-clock processor wrapper. Switches drive the 16-bit instruction in; this block drives the 16-bit result out to a 4-digit, common-anode, multiplexed seven-segment display.
- Captures the result word on a strobe and scans it as four hex digits, with optional leading-zero suppression and a "new value" decimal-point flag.
- Runs on the fast board clock, not the divided processor clock.

---
 rtl/seg7_result_display.sv | 142 ++++++++++++++
 tb/tb_seg7_result_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_result_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_result_display
// Purpose  : Captures a 16-bit result word on a strobe and scans it as four
//            hex digits on a 4-digit, common-anode, multiplexed seven-segment
//            display. Optional leading-zero blanking; the decimal point on
//            digit 0 flags a newly changed value for one full scan.
// Ports    : clk    - board clock (rising edge)
//            reset  - asynchronous, active-high reset
//            value  - result word to display
//            load   - capture strobe, value sampled on every edge it is high
//            blank  - forces the display dark while high
//            an     - digit anodes, active-low, registered
//            seg    - segments {g,f,e,d,c,b,a}, active-low, registered
//            dp     - decimal point, active-low, registered
// Revision : 1.0 - initial release
// ============================================================================
module seg7_result_display #(
    parameter int PRESCALE_BITS = 16,
    parameter bit LZ_SUPPRESS   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [3:0] c_AN_OFF  = 4'b1111;
    localparam logic [6:0] c_SEG_OFF = 7'b1111111;

    logic [PRESCALE_BITS-1:0] r_prescaler;
    logic [1:0]               r_idx;
    logic [15:0]              r_disp;
    logic                     r_new_flag;
    logic [3:0]               r_an;
    logic [6:0]               r_seg;
    logic                     r_dp;

    logic [PRESCALE_BITS-1:0] w_prescaler_nxt;
    logic [1:0]               w_idx_nxt;
    logic [15:0]              w_disp_nxt;
    logic                     w_new_flag_nxt;
    logic                     w_tick;
    logic [15:0]              w_upper;
    logic                     w_suppress;
    logic [6:0]               w_hex;
    logic [3:0]               w_an_nxt;
    logic [6:0]               w_seg_nxt;
    logic                     w_dp_nxt;

    // ------------------------------------------------------------------------
    // Scan timing, capture and new-value flag
    // ------------------------------------------------------------------------
    always_comb begin
        w_tick          = &r_prescaler;
        w_prescaler_nxt = r_prescaler + 1'b1;
        w_idx_nxt       = w_tick ? r_idx + 2'd1 : r_idx;
        w_disp_nxt      = load ? value : r_disp;

        // Clear at the end of a full scan; a changing load on the same edge
        // is applied afterwards so the set takes priority.
        w_new_flag_nxt = r_new_flag;
        if (w_tick && (r_idx == 2'd3)) begin
            w_new_flag_nxt = 1'b0;
        end
        if (load && (value != r_disp)) begin
            w_new_flag_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Digit selection, suppression and segment encoding
    // ------------------------------------------------------------------------
    always_comb begin
        // Shifting the selected nibble to the bottom also leaves exactly the
        // bits disp[15:4k] in w_upper, which drives the leading-zero test.
        w_upper    = r_disp >> {r_idx, 2'b00};
        w_suppress = LZ_SUPPRESS && (r_idx != 2'd0) && (w_upper == 16'h0000);

        case (w_upper[3:0])
            4'h0:    w_hex = 7'b1000000;
            4'h1:    w_hex = 7'b1111001;
            4'h2:    w_hex = 7'b0100100;
            4'h3:    w_hex = 7'b0110000;
            4'h4:    w_hex = 7'b0011001;
            4'h5:    w_hex = 7'b0010010;
            4'h6:    w_hex = 7'b0000010;
            4'h7:    w_hex = 7'b1111000;
            4'h8:    w_hex = 7'b0000000;
            4'h9:    w_hex = 7'b0010000;
            4'hA:    w_hex = 7'b0001000;
            4'hB:    w_hex = 7'b0000011;
            4'hC:    w_hex = 7'b1000110;
            4'hD:    w_hex = 7'b0100001;
            4'hE:    w_hex = 7'b0000110;
            default: w_hex = 7'b0001110;
        endcase

        if (blank || w_suppress) begin
            w_an_nxt  = c_AN_OFF;
            w_seg_nxt = c_SEG_OFF;
        end else begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = w_hex;
        end

        w_dp_nxt = ~((r_idx == 2'd0) && r_new_flag && !blank);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescaler <= '0;
            r_idx       <= 2'd0;
            r_disp      <= 16'h0000;
            r_new_flag  <= 1'b0;
            r_an        <= c_AN_OFF;
            r_seg       <= c_SEG_OFF;
            r_dp        <= 1'b1;
        end else begin
            r_prescaler <= w_prescaler_nxt;
            r_idx       <= w_idx_nxt;
            r_disp      <= w_disp_nxt;
            r_new_flag  <= w_new_flag_nxt;
            r_an        <= w_an_nxt;
            r_seg       <= w_seg_nxt;
            r_dp        <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg7_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_result_display
// Purpose  : Self-checking bench for seg7_result_display. Two instances share
//            stimulus (leading-zero blanking off and on) and are compared each
//            cycle against a cycle-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_result_display;

    localparam int PB     = 2;
    localparam int PERIOD = 1 << PB;       // clocks per digit
    localparam int SCAN   = 4 * PERIOD;    // clocks per full scan

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_cnt  = 0;
    logic [15:0] m_disp = 16'h0000;
    bit          m_flag = 1'b0;
    logic [3:0]  e0_an, e1_an;
    logic [6:0]  e0_seg, e1_seg;
    logic        e0_dp, e1_dp;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_result_display #(.PRESCALE_BITS(PB), .LZ_SUPPRESS(1'b0)) u_dut_lz0 (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank(blank),
        .an(an0), .seg(seg0), .dp(dp0)
    );

    seg7_result_display #(.PRESCALE_BITS(PB), .LZ_SUPPRESS(1'b1)) u_dut_lz1 (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank(blank),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Expected pin values for the model state as it stands before a clock edge
    task automatic model_out(input bit lz, input bit blk,
                             output logic [3:0] e_an, output logic [6:0] e_seg,
                             output logic e_dp);
        int  k;
        bit  lit;
        k   = (m_cnt / PERIOD) % 4;
        lit = !blk && !(lz && k > 0 && int'(m_disp) < (1 << (4 * k)));
        e_an  = lit ? (4'hF ^ 4'(1 << k)) : 4'hF;
        e_seg = lit ? hex_tab[(int'(m_disp) / (1 << (4 * k))) % 16] : 7'h7F;
        e_dp  = !(k == 0 && m_flag && !blk);
    endtask

    task automatic check_outs(input string where);
        chk({where, ".an0"},  {12'h000, an0},  {12'h000, e0_an});
        chk({where, ".seg0"}, {9'h000, seg0},  {9'h000, e0_seg});
        chk({where, ".dp0"},  {15'h0000, dp0}, {15'h0000, e0_dp});
        chk({where, ".an1"},  {12'h000, an1},  {12'h000, e1_an});
        chk({where, ".seg1"}, {9'h000, seg1},  {9'h000, e1_seg});
        chk({where, ".dp1"},  {15'h0000, dp1}, {15'h0000, e1_dp});
    endtask

    // One clock: drive inputs (just after a falling edge), advance the model
    // across the rising edge, compare on the following falling edge.
    task automatic step(input bit ld, input logic [15:0] v, input bit blk);
        load  = ld;
        value = v;
        blank = blk;
        @(posedge clk);
        model_out(1'b0, blk, e0_an, e0_seg, e0_dp);
        model_out(1'b1, blk, e1_an, e1_seg, e1_dp);
        if (m_cnt % SCAN == SCAN - 1) m_flag = 1'b0;
        if (ld && v != m_disp)        m_flag = 1'b1;
        if (ld)                       m_disp = v;
        m_cnt++;
        @(negedge clk);
        check_outs("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
    endtask

    // Called just after a falling edge; reset is raised between clock edges
    // so the dark outputs prove the asynchronous path.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        m_cnt  = 0;
        m_disp = 16'h0000;
        m_flag = 1'b0;
        e0_an = 4'hF; e0_seg = 7'h7F; e0_dp = 1'b1;
        e1_an = 4'hF; e1_seg = 7'h7F; e1_dp = 1'b1;
        check_outs("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_outs("rst_held");
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        bit          blk_r;

        @(negedge clk);
        do_reset();

        // Full-width value with no blanking on either instance
        step(1'b1, 16'h1A3F, 1'b0);
        idle(2 * SCAN);

        // Reset in the middle of a scan restarts at digit 0
        idle(6);
        do_reset();
        idle(SCAN);

        // Leading-zero cases
        step(1'b1, 16'h0000, 1'b0);
        idle(SCAN + 2);
        step(1'b1, 16'h00C0, 1'b0);
        idle(SCAN + 2);

        // New-value flag: set, clear on wrap, identical reload keeps it clear
        step(1'b1, 16'h0000, 1'b0);
        idle(SCAN + 2);
        step(1'b1, 16'h1234, 1'b0);
        idle(2 * SCAN);
        step(1'b1, 16'h1234, 1'b0);
        idle(2 * SCAN);

        // Changing load exactly on the 3->0 wrap tick
        while (m_cnt % SCAN != SCAN - 1) step(1'b0, 16'h0000, 1'b0);
        step(1'b1, 16'h5678, 1'b0);
        idle(2 * SCAN);

        // Blank for 20 clocks mid-scan, with a capture during blanking
        idle(5);
        for (int i = 0; i < 20; i++) step(i == 7, 16'h9ABC, 1'b1);
        idle(2 * SCAN);

        // Back-to-back loads: last one displayed, flag set
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h0003, 1'b0);
        idle(2 * SCAN);

        // Randomized traffic
        blk_r = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom());
                1:       v = 16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3));
                2:       v = 16'h0000;
                default: v = m_disp;
            endcase
            if ($urandom_range(0, 24) == 0) blk_r = ~blk_r;
            step($urandom_range(0, 5) == 0, v, blk_r);
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
